// File: rtl/fpu_operand_feeder_if.sv
// Operand-pair bus between the pair source, the operand feeder and the FPU adder inputs.
// The master side offers pairs and observes status; the slave side is the feeder itself.
interface fpu_operand_feeder_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_op_a;
    logic [31:0]      in_op_b;
    logic [31:0]      Op_A_out;
    logic [31:0]      Op_B_out;
    logic             op_valid;
    logic [CNT_W-1:0] pair_count;
    logic             busy;

    modport master (
        output in_valid, in_op_a, in_op_b,
        input  in_ready, Op_A_out, Op_B_out, op_valid, pair_count, busy
    );

    modport slave (
        input  in_valid, in_op_a, in_op_b,
        output in_ready, Op_A_out, Op_B_out, op_valid, pair_count, busy
    );
endinterface

// File: rtl/fpu_operand_feeder.sv
// Queues FPU operand pairs and presents each one for a fixed window long enough for one FPU pass.
// Defining FEEDER_STATS_EN adds the 16-bit pairs_issued counter port.
module fpu_operand_feeder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 32
) (
    input  logic                 clock_100Khz,
    input  logic                 reset,
    fpu_operand_feeder_if.slave  bus
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]          pairs_issued
`endif
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [63:0]       mem [DEPTH];
    logic              push;
    logic              pop;

    assign bus.in_ready   = (count != CNT_W'(DEPTH));
    assign bus.pair_count = count;
    assign bus.busy       = (state != IDLE);
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = (state == LOAD);

    // Payload storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock_100Khz) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_op_a, bus.in_op_b};
        end
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // The FPU has no input handshake, so the hold window is the only pacing toward it.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            bus.Op_A_out <= '0;
            bus.Op_B_out <= '0;
            bus.op_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bus.Op_A_out <= mem[rd_ptr][63:32];
                    bus.Op_B_out <= mem[rd_ptr][31:0];
                    bus.op_valid <= 1'b1;
                    hold_cnt     <= HOLD_W'(HOLD_CYCLES - 1);
                    state        <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        if (count != '0) begin
                            state <= LOAD;
                        end else begin
                            state        <= IDLE;
                            bus.op_valid <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            pairs_issued <= '0;
        end else if (pop) begin
            pairs_issued <= pairs_issued + 16'd1;
        end
    end
`endif

endmodule
